lpc_alpha_calc: RTL and testbench

Computes the Levinson–Durbin numerator α_m = R[m+1] + Σ_{i=1..m} a_m[i]·R[m+1−i] in IEEE-754 single precision. It reads the autocorrelation and current-order LPC coefficient memories through registered read ports. The resulting α_m feeds the reflection-coefficient/error stage, which returns k_{m+1} and E_{m+1} to the coefficient updater. Its operands come from memories, and it issues one α per order step under a start/valid handshake.

---
 rtl/lpc_fp_pkg.sv | 168 ++++++++++++++++
 rtl/fp_add_sub.sv | 32 +++
 rtl/fp_mult.sv | 28 ++
 rtl/lpc_alpha_calc.sv | 187 ++++++++++++++++++
 tb/tb_lpc_alpha_calc.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lpc_fp_pkg.sv
// Shared constants, FSM encoding and IEEE-754 single-precision helpers for the LPC datapath.
// Denormal operands are flushed to zero; rounding is round-to-nearest-even.
package lpc_fp_pkg;

    localparam int          LPC_MAX_ORDER    = 32;
    localparam int          LPC_MULT_LATENCY = 5;
    localparam int          LPC_ADD_LATENCY  = 7;
    localparam logic [31:0] FP_QNAN          = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_INIT_CAP = 3'd2,
        ST_FETCH    = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_MULT     = 3'd5,
        ST_ADD      = 3'd6,
        ST_DONE     = 3'd7
    } lpc_state_e;

    function automatic logic [31:0] fp_mul_f(input logic [31:0] a, input logic [31:0] b);
        logic              sgn;
        logic [7:0]        ea;
        logic [7:0]        eb;
        logic [47:0]       p;
        logic [23:0]       m;
        logic [24:0]       rnd;
        logic              g;
        logic              st;
        logic signed [9:0] e;
        logic [31:0]       res;
        sgn = a[31] ^ b[31];
        ea  = a[30:23];
        eb  = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0)) begin
            res = FP_QNAN;
        end else if (ea == 8'hFF || eb == 8'hFF) begin
            res = (ea == 8'd0 || eb == 8'd0) ? FP_QNAN : {sgn, 8'hFF, 23'd0};
        end else if (ea == 8'd0 || eb == 8'd0) begin
            res = {sgn, 31'd0};
        end else begin
            p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
            if (p[47]) begin
                m  = p[47:24];
                g  = p[23];
                st = |p[22:0];
                e  = e + 10'sd1;
            end else begin
                m  = p[46:23];
                g  = p[22];
                st = |p[21:0];
            end
            rnd = {1'b0, m} + {24'd0, g & (st | m[0])};
            if (rnd[24]) begin
                rnd = rnd >> 1;
                e   = e + 10'sd1;
            end else begin
                rnd = rnd;
            end
            if (e >= 10'sd255) begin
                res = {sgn, 8'hFF, 23'd0};
            end else if (e <= 10'sd0) begin
                res = {sgn, 31'd0};
            end else begin
                res = {sgn, e[7:0], rnd[22:0]};
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] fp_add_f(input logic [31:0] a, input logic [31:0] b);
        logic              sl;
        logic [7:0]        ea;
        logic [7:0]        eb;
        logic [7:0]        el;
        logic [7:0]        d;
        logic [26:0]       ml;
        logic [26:0]       msm;
        logic [26:0]       msh;
        logic [53:0]       wide;
        logic [27:0]       sum;
        logic [26:0]       nrm;
        logic [24:0]       rnd;
        logic signed [9:0] e;
        int                lead;
        logic [31:0]       res;
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0)) begin
            res = FP_QNAN;
        end else if (ea == 8'hFF && eb == 8'hFF) begin
            res = (a[31] != b[31]) ? FP_QNAN : a;
        end else if (ea == 8'hFF) begin
            res = a;
        end else if (eb == 8'hFF) begin
            res = b;
        end else if (ea == 8'd0 && eb == 8'd0) begin
            res = {a[31] & b[31], 31'd0};
        end else if (ea == 8'd0) begin
            res = b;
        end else if (eb == 8'd0) begin
            res = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin
                sl  = a[31];
                el  = ea;
                d   = ea - eb;
                ml  = {1'b1, a[22:0], 3'b000};
                msm = {1'b1, b[22:0], 3'b000};
            end else begin
                sl  = b[31];
                el  = eb;
                d   = eb - ea;
                ml  = {1'b1, b[22:0], 3'b000};
                msm = {1'b1, a[22:0], 3'b000};
            end
            // Alignment keeps guard/round bits plus a sticky bit in the LSB.
            if (d > 8'd26) begin
                msh = 27'd1;
            end else begin
                wide = {msm, 27'd0} >> d;
                msh  = wide[53:27] | {26'd0, |wide[26:0]};
            end
            if (a[31] == b[31]) begin
                sum = {1'b0, ml} + {1'b0, msh};
            end else begin
                sum = {1'b0, ml} - {1'b0, msh};
            end
            e = $signed({2'b00, el});
            if (sum == 28'd0) begin
                res = 32'h0000_0000;
            end else begin
                if (sum[27]) begin
                    nrm = {sum[27:2], sum[1] | sum[0]};
                    e   = e + 10'sd1;
                end else begin
                    lead = 0;
                    for (int k = 0; k < 27; k++) begin
                        if (sum[k]) begin
                            lead = k;
                        end else begin
                            lead = lead;
                        end
                    end
                    nrm = sum[26:0] << (26 - lead);
                    e   = e - 10'(26 - lead);
                end
                rnd = {1'b0, nrm[26:3]} + {24'd0, nrm[2] & ((|nrm[1:0]) | nrm[3])};
                if (rnd[24]) begin
                    rnd = rnd >> 1;
                    e   = e + 10'sd1;
                end else begin
                    rnd = rnd;
                end
                if (e >= 10'sd255) begin
                    res = {sl, 8'hFF, 23'd0};
                end else if (e <= 10'sd0) begin
                    res = {sl, 31'd0};
                end else begin
                    res = {sl, e[7:0], rnd[22:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_add_sub.sv
// Single-precision adder/subtractor (add_sub=1 adds); result valid after LATENCY enabled cycles.
module fp_add_sub
    import lpc_fp_pkg::*;
#(
    parameter int LATENCY = LPC_ADD_LATENCY
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        add_sub,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    logic [31:0] pipe_r [LATENCY-1];
    logic [31:0] b_eff_s;

    assign b_eff_s = add_sub ? datab : {~datab[31], datab[30:0]};

    // Pipeline advances only while enabled; contents are never cleared.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            pipe_r[0] <= fp_add_f(dataa, b_eff_s);
            for (int k = 1; k < LATENCY - 1; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    assign result = pipe_r[LATENCY-2];

endmodule

// File: rtl/fp_mult.sv
// Single-precision multiplier; result valid after LATENCY enabled cycles of stable operands.
module fp_mult
    import lpc_fp_pkg::*;
#(
    parameter int LATENCY = LPC_MULT_LATENCY
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    logic [31:0] pipe_r [LATENCY-1];

    // Pipeline advances only while enabled; contents are never cleared.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            pipe_r[0] <= fp_mul_f(dataa, datab);
            for (int k = 1; k < LATENCY - 1; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    assign result = pipe_r[LATENCY-2];

endmodule

// File: rtl/lpc_alpha_calc.sv
// Levinson-Durbin numerator: alpha_m = R[m+1] + sum_{i=1..m} a_m[i]*R[m+1-i], accumulated in order.
// Read addresses are issued one state ahead so registered memory data lands in the consuming state.
module lpc_alpha_calc
    import lpc_fp_pkg::*;
#(
    parameter int MAX_ORDER    = LPC_MAX_ORDER,
    parameter int MULT_LATENCY = LPC_MULT_LATENCY,
    parameter int ADD_LATENCY  = LPC_ADD_LATENCY
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iEnable,
    input  logic        iStart,
    input  logic [4:0]  iM,
    output logic [5:0]  oRAddr,
    input  logic [31:0] iRData,
    output logic [4:0]  oAAddr,
    input  logic [31:0] iAData,
    output logic [31:0] oAlpha,
    output logic        oValid,
    output logic        oBusy
);

    lpc_state_e  state_r, state_nxt_s;
    logic [4:0]  m_r, m_nxt_s, m_sat_s;
    logic [4:0]  i_r, i_nxt_s;
    logic [3:0]  lat_r, lat_nxt_s;
    logic [31:0] acc_r, acc_nxt_s;
    logic [31:0] op_a_r, op_a_nxt_s;
    logic [31:0] op_b_r, op_b_nxt_s;
    logic [31:0] prod_r, prod_nxt_s;
    logic [31:0] alpha_r, alpha_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic [5:0]  r_addr_r, r_addr_nxt_s;
    logic [4:0]  a_addr_r, a_addr_nxt_s;
    logic        mult_en_s, add_en_s;
    logic [31:0] mult_res_s, add_res_s;

    assign m_sat_s   = (int'(iM) > MAX_ORDER - 1) ? 5'(MAX_ORDER - 1) : iM;
    assign mult_en_s = iEnable & (state_r == ST_MULT);
    assign add_en_s  = iEnable & (state_r == ST_ADD);

    fp_mult #(.LATENCY(MULT_LATENCY)) u_mult (
        .clk    (iClock),
        .clk_en (mult_en_s),
        .dataa  (op_a_r),
        .datab  (op_b_r),
        .result (mult_res_s)
    );

    fp_add_sub #(.LATENCY(ADD_LATENCY)) u_add (
        .clk     (iClock),
        .clk_en  (add_en_s),
        .add_sub (1'b1),
        .dataa   (acc_r),
        .datab   (prod_r),
        .result  (add_res_s)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_nxt_s  = state_r;
        m_nxt_s      = m_r;
        i_nxt_s      = i_r;
        lat_nxt_s    = lat_r;
        acc_nxt_s    = acc_r;
        op_a_nxt_s   = op_a_r;
        op_b_nxt_s   = op_b_r;
        prod_nxt_s   = prod_r;
        r_addr_nxt_s = r_addr_r;
        a_addr_nxt_s = a_addr_r;
        case (state_r)
            ST_IDLE: begin
                if (iStart) begin
                    m_nxt_s      = m_sat_s;
                    i_nxt_s      = 5'd1;
                    r_addr_nxt_s = {1'b0, m_sat_s} + 6'd1;
                    state_nxt_s  = ST_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_nxt_s = ST_INIT_CAP;
            end
            ST_INIT_CAP: begin
                acc_nxt_s = iRData;
                if (m_r == 5'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    a_addr_nxt_s = i_r;
                    r_addr_nxt_s = {1'b0, m_r} + 6'd1 - {1'b0, i_r};
                    state_nxt_s  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                op_a_nxt_s  = iAData;
                op_b_nxt_s  = iRData;
                lat_nxt_s   = 4'd0;
                state_nxt_s = ST_MULT;
            end
            ST_MULT: begin
                if (lat_r == 4'(MULT_LATENCY - 1)) begin
                    prod_nxt_s  = mult_res_s;
                    lat_nxt_s   = 4'd0;
                    state_nxt_s = ST_ADD;
                end else begin
                    lat_nxt_s = lat_r + 4'd1;
                end
            end
            ST_ADD: begin
                if (lat_r == 4'(ADD_LATENCY - 1)) begin
                    acc_nxt_s = add_res_s;
                    lat_nxt_s = 4'd0;
                    if (i_r == m_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        // Next term reads a[i+1] and R[m+1-(i+1)] = R[m-i].
                        i_nxt_s      = i_r + 5'd1;
                        a_addr_nxt_s = i_r + 5'd1;
                        r_addr_nxt_s = {1'b0, m_r - i_r};
                        state_nxt_s  = ST_FETCH;
                    end
                end else begin
                    lat_nxt_s = lat_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (state_nxt_s == ST_DONE) begin
            alpha_nxt_s = acc_nxt_s;
        end else begin
            alpha_nxt_s = alpha_r;
        end
        valid_nxt_s = (state_nxt_s == ST_DONE);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
    end

    // State and datapath registers; everything freezes while iEnable is low.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_r  <= ST_IDLE;
            m_r      <= 5'd0;
            i_r      <= 5'd0;
            lat_r    <= 4'd0;
            acc_r    <= 32'd0;
            op_a_r   <= 32'd0;
            op_b_r   <= 32'd0;
            prod_r   <= 32'd0;
            alpha_r  <= 32'd0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            r_addr_r <= 6'd0;
            a_addr_r <= 5'd0;
        end else if (iEnable) begin
            state_r  <= state_nxt_s;
            m_r      <= m_nxt_s;
            i_r      <= i_nxt_s;
            lat_r    <= lat_nxt_s;
            acc_r    <= acc_nxt_s;
            op_a_r   <= op_a_nxt_s;
            op_b_r   <= op_b_nxt_s;
            prod_r   <= prod_nxt_s;
            alpha_r  <= alpha_nxt_s;
            valid_r  <= valid_nxt_s;
            busy_r   <= busy_nxt_s;
            r_addr_r <= r_addr_nxt_s;
            a_addr_r <= a_addr_nxt_s;
        end
    end

    assign oRAddr = r_addr_r;
    assign oAAddr = a_addr_r;
    assign oAlpha = alpha_r;
    assign oValid = valid_r;
    assign oBusy  = busy_r;

endmodule

// File: tb/tb_lpc_alpha_calc.sv
// Directed and randomized checks of lpc_alpha_calc against a real-arithmetic reference.
// Random operands are multiples of 1/8 so every product and partial sum is exact in single precision.
module tb_lpc_alpha_calc;

    localparam int ML       = 5;
    localparam int AL       = 7;
    localparam int STEP     = 2 + ML + AL;
    localparam int MAX_WAIT = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [4:0]  m_in;
    logic [5:0]  r_addr;
    logic [31:0] r_data;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic [31:0] alpha;
    logic        valid;
    logic        busy;

    logic [31:0] r_mem [0:63];
    logic [31:0] a_mem [0:31];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lpc_alpha_calc dut (
        .iClock  (clk),
        .iReset  (rst),
        .iEnable (en),
        .iStart  (start),
        .iM      (m_in),
        .oRAddr  (r_addr),
        .iRData  (r_data),
        .oAAddr  (a_addr),
        .iAData  (a_data),
        .oAlpha  (alpha),
        .oValid  (valid),
        .oBusy   (busy)
    );

    // Synchronous-read memories: data one cycle after address.
    always_ff @(posedge clk) begin
        r_data <= r_mem[r_addr];
        a_data <= a_mem[a_addr];
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic real bits2real(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        for (int k = 0; k < e; k++) v = v * 2.0;
        for (int k = 0; k > e; k--) v = v / 2.0;
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] real2bits(input real x);
        logic        s;
        int          e;
        real         v;
        logic [22:0] f;
        if (x == 0.0) return 32'h0000_0000;
        s = (x < 0.0);
        v = s ? -x : x;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        f = 23'($rtoi((v - 1.0) * 8388608.0));
        return {s, 8'(e), f};
    endfunction

    function automatic logic [31:0] rand_val();
        int k;
        k = int'($urandom_range(32, 0)) - 16;
        return real2bits(real'(k) / 8.0);
    endfunction

    function automatic logic [31:0] ref_alpha(input int m);
        real acc;
        acc = bits2real(r_mem[m+1]);
        for (int i = 1; i <= m; i++) acc = acc + bits2real(a_mem[i]) * bits2real(r_mem[m+1-i]);
        return real2bits(acc);
    endfunction

    task automatic start_run(input logic [4:0] m);
        @(negedge clk);
        check32("idle_valid", {31'd0, valid}, 32'd0);
        check32("idle_busy", {31'd0, busy}, 32'd0);
        m_in  = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the start edge until oValid; optionally stalls and pokes iStart.
    task automatic wait_valid(input int stall_at, input int stall_len, input int poke_a,
                              input int poke_b, output int cyc, output bit busy_ok);
        cyc     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) begin
                cyc = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (k == poke_a || k == poke_b) start = 1'b1;
            if (k == stall_at) en = 1'b0;
            if (k == stall_at + stall_len) en = 1'b1;
        end
        en    = 1'b1;
        start = 1'b0;
    endtask

    task automatic run_case(input string tag, input int m, input logic [31:0] exp_alpha,
                            input int stall_at, input int stall_len, input int poke_a, input int poke_b);
        int cyc;
        bit bok;
        start_run(5'(m));
        wait_valid(stall_at, stall_len, poke_a, poke_b, cyc, bok);
        check32({tag, "_lat"}, 32'(cyc), 32'(3 + m * STEP + stall_len));
        check32({tag, "_alpha"}, alpha, exp_alpha);
        check32({tag, "_busy"}, {31'd0, bok}, 32'd1);
    endtask

    task automatic load_m2();
        r_mem[1] = 32'h3F80_0000;
        r_mem[2] = 32'h3F00_0000;
        r_mem[3] = 32'h3E00_0000;
        a_mem[1] = 32'hBF00_0000;
        a_mem[2] = 32'h3E80_0000;
    endtask

    initial begin
        int          cyc;
        bit          bok;
        int          m;
        int          sl;
        int          sa;
        int          pk;
        logic [31:0] ea;

        for (int j = 0; j < 64; j++) r_mem[j] = 32'h0;
        for (int j = 0; j < 32; j++) a_mem[j] = 32'h0;
        rst   = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        m_in  = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_alpha", alpha, 32'h0);
        check32("rst_valid", {31'd0, valid}, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_raddr", {26'd0, r_addr}, 32'd0);
        check32("rst_aaddr", {27'd0, a_addr}, 32'd0);
        rst = 1'b0;

        // m = 0: alpha is simply R[1].
        r_mem[1] = 32'h3F00_0000;
        run_case("m0", 0, 32'h3F00_0000, -1, 0, -1, -1);
        check32("m0_aaddr_unused", {27'd0, a_addr}, 32'd0);

        // m = 1: 0.25 + (-0.5)(0.5) = +0.
        r_mem[2] = 32'h3E80_0000;
        a_mem[1] = 32'hBF00_0000;
        run_case("m1", 1, 32'h0000_0000, -1, 0, -1, -1);

        // m = 2: 0.125 - 0.25 + 0.25 = 0.125.
        load_m2();
        run_case("m2", 2, 32'h3E00_0000, -1, 0, -1, -1);
        check32("m2_hold_alpha", alpha, 32'h3E00_0000);

        // Five frozen cycles inside MULT.
        run_case("m2_stall", 2, 32'h3E00_0000, 7, 5, -1, -1);

        // iStart while busy is ignored; back-to-back start in the IDLE cycle after oValid.
        run_case("m2_poke", 2, 32'h3E00_0000, -1, 0, 5, 20);
        run_case("m2_b2b", 2, 32'h3E00_0000, -1, 0, -1, -1);

        // oValid held through a stall at DONE, then a single pulse.
        r_mem[1] = 32'h3F00_0000;
        r_mem[2] = 32'h3E80_0000;
        a_mem[1] = 32'h3F00_0000;
        start_run(5'd1);
        wait_valid(-1, 0, -1, -1, cyc, bok);
        check32("hold_lat", 32'(cyc), 32'(3 + STEP));
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check32("hold_valid", {31'd0, valid}, 32'd1);
            check32("hold_alpha", alpha, 32'h3F00_0000);
        end
        en = 1'b1;
        @(negedge clk);
        check32("hold_release", {31'd0, valid}, 32'd0);

        // Reset mid-MULT, then a fresh m = 1 run: 0.25 + 0.5*0.5 = 0.5.
        load_m2();
        start_run(5'd2);
        for (int k = 1; k <= 8; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check32("midrst_alpha", alpha, 32'h0);
        check32("midrst_valid", {31'd0, valid}, 32'd0);
        check32("midrst_busy", {31'd0, busy}, 32'd0);
        check32("midrst_raddr", {26'd0, r_addr}, 32'd0);
        check32("midrst_aaddr", {27'd0, a_addr}, 32'd0);
        rst = 1'b0;
        r_mem[1] = 32'h3F00_0000;
        r_mem[2] = 32'h3E80_0000;
        a_mem[1] = 32'h3F00_0000;
        run_case("after_rst", 1, 32'h3F00_0000, -1, 0, -1, -1);

        // Randomized runs; the first uses the highest order.
        for (int t = 0; t < 8; t++) begin
            m = (t == 0) ? 31 : int'($urandom_range(30, 1));
            for (int j = 0; j <= 32; j++) r_mem[j] = rand_val();
            for (int j = 1; j <= 31; j++) a_mem[j] = rand_val();
            ea = ref_alpha(m);
            sl = int'($urandom_range(3, 0));
            sa = int'($urandom_range(32'(3 + m * STEP - 1), 1));
            pk = int'($urandom_range(32'(3 + m * STEP - 1), 1));
            run_case($sformatf("rnd%0d_m%0d", t, m), m, ea, sa, sl, pk, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
